handshake_rr_arbiter: RTL and testbench
=======================================

# handshake_rr_arbiter

Round-robin arbiter that shares one handshake output channel between `NUM_INPUTS` requesting channels in the dataflow circuit. It picks at most one valid requester per cycle and forwards its data word plus the winner's index. The result goes through a single-slot registered output stage. It sits in front of a shared consumer (shared unit, constant/control fan-in), so several producers can drive it without combinational valid/ready loops across the share point.

## Interface
Parameters:
- `NUM_INPUTS`, 4: number of requester channels; legal range ≥ 2.
- `DATA_WIDTH`, 32: width of each data word.
- `INDEX_WIDTH`, 2: width of the winner index; must equal ceil(log2(`NUM_INPUTS`)).

Ports:
- `clk`, input, 1: the single clock; all state updates on the rising edge.
- `rst`, input, 1: reset, asynchronous, active-low (0 = reset asserted).
- `ins`, input, `NUM_INPUTS*DATA_WIDTH`: requester data, packed; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `ins_valid`, input, `NUM_INPUTS`: per-requester valid.
- `ins_ready`, output, `NUM_INPUTS`: per-requester ready; one-hot or all-zero.
- `outs`, output, `DATA_WIDTH`: registered data of the granted token.
- `index`, output, `INDEX_WIDTH`: registered index of the granted requester; qualified by `outs_valid`.
- `outs_valid`, output, 1: output slot holds a token.
- `outs_ready`, input, 1: consumer accepts the token.

## Operation
- State:
  - `ptr`: the round-robin priority pointer, `INDEX_WIDTH` bits.
  - `full`: output slot occupied (`outs_valid` = `full`).
  - `outs` and `index` registers.
- Load enable: `load = !full || outs_ready`.
- Arbitration (combinational):
  - Scan requesters starting at `ptr`, going upward and wrapping modulo `NUM_INPUTS`.
  - The first i with `ins_valid[i]` = 1 is the winner `w`.
  - `ins_ready[w] = load`. Every other `ins_ready` bit is 0.
- Transfer on requester w: `ins_valid[w] && ins_ready[w]`. At the clock edge:
  - `outs` ← `ins[w]`, `index` ← w, `full` ← 1.
  - `ptr` ← (w+1) mod `NUM_INPUTS`. This wraps from `NUM_INPUTS`-1 to 0, and also holds for non-power-of-2 `NUM_INPUTS`.
- Output consumed with no transfer: `full && outs_ready` with no requester valid → `full` ← 0.
- Stall: `full && !outs_ready` → all `ins_ready` are 0; `outs`, `index`, `full` and `ptr` hold.
- No valid requester → `ptr` holds. The pointer advances only on a grant.
- `ins_ready` never depends on `ins_valid` of the channel itself beyond winner selection. A requester must keep its valid and data stable until it is accepted. The block does not check this.
- Reset (`rst` = 0, any time, including mid-transfer):
  - `full` = 0, so `outs_valid` = 0.
  - `outs` = 0, `index` = 0, `ptr` = 0.
  - `ins_ready` = 0 while reset is asserted.
  - A held token is discarded.

## Timing
- Latency: a token accepted in cycle n appears on `outs`/`index` with `outs_valid` = 1 in cycle n+1.
- Throughput: one token per cycle while `outs_ready` = 1. The slot is drained and refilled in the same edge.
- Combinational paths:
  - `outs_ready` → `ins_ready`.
  - `ins_valid` → `ins_ready`.
  - No path from `ins_*` to `outs`, `index` or `outs_valid`; all three are registered.
- Fairness: with all requesters continuously valid and `outs_ready` = 1, grants cycle 0,1,…,N-1,0,…. Any continuously valid requester waits at most `NUM_INPUTS`-1 grants.
- Simultaneous drain and refill: `full`, `outs_ready` = 1 and a winner present give one transfer; `full` stays 1 and the output carries the new data.
- Reset release: the first grant is possible in the first cycle with `rst` = 1. Priority starts at requester 0.

## Test plan
Defaults: `NUM_INPUTS` = 4, `DATA_WIDTH` = 32.
- Reset: drive `rst` = 0 with all inputs valid → `outs_valid` = 0, `outs` = 0, `index` = 0, `ins_ready` = 4'b0000. Release `rst` → the first grant goes to ch0.
- Full contention: all 4 valid, `ins[i]` = 0x10+i, `outs_ready` = 1 → `index` sequence 0,1,2,3,0,… one per cycle, with `outs` = 0x10,0x11,0x12,0x13,0x10.
- Backpressure: hold a token, then `outs_ready` = 0 for 5 cycles with ch2 valid → `ins_ready` = 0 throughout and `outs`/`index` stable. Raise `outs_ready` → ch2 is accepted in that same cycle and appears the next cycle.
- Sparse and wrap: only ch3 valid, then only ch1 valid → grants 3 then 1. After the ch1 grant, ch0 and ch1 both valid → the next grant is ch0 (the pointer wrapped to 2 and scans 2,3,0).
- Idle drain: one token, then no valid requester with `outs_ready` = 1 → `outs_valid` falls after one cycle and the pointer is unchanged.
- Mid-operation reset: assert `rst` = 0 while `full` = 1 and `outs_ready` = 0 → `outs_valid` drops immediately (asynchronous reset) and the token is lost. After release, arbitration restarts from ch0.

Source files
------------

// File: rtl/handshake_rr_arbiter.sv
// Round-robin arbiter merging NUM_INPUTS handshake channels into one registered output slot.
// The winner's data and index are forwarded, and priority rotates past each grant.
module handshake_rr_arbiter #(
  parameter int unsigned NUM_INPUTS  = 4,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned INDEX_WIDTH = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] ins,
  input  logic [NUM_INPUTS-1:0]            ins_valid,
  output logic [NUM_INPUTS-1:0]            ins_ready,
  output logic [DATA_WIDTH-1:0]            outs,
  output logic [INDEX_WIDTH-1:0]           index,
  output logic                             outs_valid,
  input  logic                             outs_ready
);

  typedef enum logic {EMPTY, FULL} slot_t;

  slot_t                  state, next_state;
  logic [INDEX_WIDTH-1:0] ptr;
  logic [INDEX_WIDTH-1:0] win;
  logic                   found;
  logic                   load;
  logic                   transfer;

  assign load     = (state == EMPTY) || outs_ready;
  assign transfer = found && load && rst;

  // Scan upward from ptr with wrap; the first valid requester wins.
  always_comb begin
    int unsigned idx;
    found = 1'b0;
    win   = '0;
    for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
      idx = (32'(ptr) + k) % NUM_INPUTS;
      if (!found && ins_valid[idx]) begin
        found = 1'b1;
        win   = INDEX_WIDTH'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= EMPTY;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    if (transfer) begin
      next_state = FULL;
    end else if (outs_ready) begin
      next_state = EMPTY;
    end
  end

  always_comb begin
    outs_valid = (state == FULL);
    ins_ready  = '0;
    if (transfer) begin
      ins_ready[win] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outs  <= '0;
      index <= '0;
      ptr   <= '0;
    end else if (transfer) begin
      outs  <= ins[32'(win)*DATA_WIDTH +: DATA_WIDTH];
      index <= win;
      // Explicit wrap keeps non-power-of-2 channel counts correct.
      ptr   <= (32'(win) == NUM_INPUTS - 1) ? '0 : win + 1'b1;
    end
  end

endmodule

// File: tb/tb_handshake_rr_arbiter.sv
// Directed and randomized checks of handshake_rr_arbiter against a distance-based
// round-robin reference model.
module tb_handshake_rr_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*DW-1:0] ins;
  logic [N-1:0]    ins_valid;
  logic [N-1:0]    ins_ready;
  logic [DW-1:0]   outs;
  logic [IW-1:0]   index;
  logic            outs_valid;
  logic            outs_ready;

  int checks = 0;
  int errors = 0;

  int            m_ptr;
  int            m_idx;
  bit            m_full;
  logic [DW-1:0] m_outs;

  handshake_rr_arbiter #(.NUM_INPUTS(N), .DATA_WIDTH(DW), .INDEX_WIDTH(IW)) dut (
    .clk(clk), .rst(rst), .ins(ins), .ins_valid(ins_valid), .ins_ready(ins_ready),
    .outs(outs), .index(index), .outs_valid(outs_valid), .outs_ready(outs_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_ptr = 0; m_idx = 0; m_full = 0; m_outs = '0;
  endfunction

  // Winner = valid channel with the smallest forward distance from the pointer.
  function automatic int winner();
    int best = -1;
    int bd = N;
    for (int i = 0; i < N; i++) begin
      if (ins_valid[i]) begin
        int d;
        d = (i - m_ptr + N) % N;
        if (d < bd) begin bd = d; best = i; end
      end
    end
    return best;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    int w;
    w = winner();
    if (!rst || w < 0 || (m_full && !outs_ready)) return '0;
    return N'(1) << w;
  endfunction

  function automatic logic [DW-1:0] chan(input int i);
    return ins[i*DW +: DW];
  endfunction

  // Check current outputs against the model, then advance one clock edge.
  task automatic cycle(input string tag);
    int w;
    #2;
    check({tag, "/valid"}, outs_valid, m_full);
    check({tag, "/outs"}, outs, m_outs);
    check({tag, "/index"}, index, m_idx);
    check({tag, "/ready"}, ins_ready, exp_ready());
    @(posedge clk);
    if (rst) begin
      w = winner();
      if (w >= 0 && (!m_full || outs_ready)) begin
        m_outs = chan(w); m_idx = w; m_full = 1; m_ptr = (w + 1) % N;
      end else if (m_full && outs_ready) begin
        m_full = 0;
      end
    end
    #1;
  endtask

  initial begin
    rst = 1'b0;
    outs_ready = 1'b1;
    ins_valid = '1;
    for (int i = 0; i < N; i++) ins[i*DW +: DW] = DW'(32'h10 + i);
    model_reset();

    // Reset held with everything valid
    repeat (2) cycle("reset");
    check("reset_ready", ins_ready, 4'b0000);
    check("reset_valid", outs_valid, 1'b0);

    // Release: ch0 wins first, then full contention rotates 0,1,2,3,0
    #1 rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle("contend");
      check("contend_idx", index, k % N);
      check("contend_data", outs, 32'h10 + (k % N));
    end

    // Backpressure with ch2 waiting
    ins_valid = 4'b0100;
    outs_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle("stall");
      check("stall_ready", ins_ready, 4'b0000);
      check("stall_idx", index, 0);
      check("stall_data", outs, 32'h10);
    end
    outs_ready = 1'b1;
    #2 check("unstall_ready", ins_ready, 4'b0100);
    cycle("unstall");
    check("unstall_idx", index, 2);

    // Sparse requests and pointer wrap
    ins_valid = 4'b1000; cycle("sparse3"); check("sparse3_idx", index, 3);
    ins_valid = 4'b0010; cycle("sparse1"); check("sparse1_idx", index, 1);
    ins_valid = 4'b0011; cycle("wrap");    check("wrap_idx", index, 0);

    // Idle drain keeps pointer at 1
    ins_valid = 4'b0000; cycle("drain");
    check("drain_valid", outs_valid, 1'b0);
    ins_valid = 4'b1111; cycle("after_drain");
    check("after_drain_idx", index, 1);

    // Asynchronous reset while holding a stalled token
    outs_ready = 1'b0; ins_valid = '0;
    cycle("hold");
    #2 rst = 1'b0;
    #1;
    model_reset();
    check("async_valid", outs_valid, 1'b0);
    check("async_idx", index, 0);
    check("async_data", outs, 0);
    check("async_ready", ins_ready, 4'b0000);
    @(posedge clk); #1;
    rst = 1'b1; ins_valid = '1; outs_ready = 1'b1;
    cycle("restart");
    check("restart_idx", index, 0);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < N; i++) ins[i*DW +: DW] = $urandom;
      ins_valid  = N'($urandom);
      outs_ready = ($urandom_range(3) != 0);
      cycle("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
